// File: rtl/femto_rf_pkg.sv
// Shared constants and types for the femtoRV32 integer register file.
package femto_rf_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int AW_DEFAULT   = 5;
   localparam int REG_ZERO     = 0;

   typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
   typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage : femto_rf_pkg

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, flush wipes all.
module reg_scoreboard
   import femto_rf_pkg::*;
#(
   parameter int unsigned AW       = AW_DEFAULT,
   parameter int unsigned NREGS    = 2 ** AW_DEFAULT,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic [AW-1:0] query1_addr,
   input  logic [AW-1:0] query2_addr,
   output logic          query1_busy,
   output logic          query2_busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             clr_ok;
   logic             set_ok;
   logic             q1_zero;
   logic             q2_zero;

   assign clr_ok  = clr_en && !(ZERO_REG && (clr_addr == AW'(REG_ZERO)));
   assign set_ok  = set_en && !(ZERO_REG && (set_addr == AW'(REG_ZERO)));
   assign q1_zero = ZERO_REG && (query1_addr == AW'(REG_ZERO));
   assign q2_zero = ZERO_REG && (query2_addr == AW'(REG_ZERO));

   // Clear is applied before set so a new producer supersedes the completing one.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (clr_ok) busy_d[clr_addr] = 1'b0;
         if (set_ok) busy_d[set_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   // A same-cycle writeback releases the stall; the data comes through the bypass.
   always_comb begin
      query1_busy = 1'b0;
      query2_busy = 1'b0;
      if (!q1_zero)
         query1_busy = busy_q[query1_addr] && !(clr_en && (clr_addr == query1_addr));
      if (!q2_zero)
         query2_busy = busy_q[query2_addr] && !(clr_en && (clr_addr == query2_addr));
   end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read/one-write integer register file with write-to-read bypass and busy scoreboard.
module reg_file_sb
   import femto_rf_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned AW       = AW_DEFAULT,
   parameter int unsigned NREGS    = 2 ** AW_DEFAULT,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   readReg1,
   input  logic [AW-1:0]   readReg2,
   output logic [XLEN-1:0] readData1,
   output logic [XLEN-1:0] readData2,
   output logic            busy1,
   output logic            busy2,
   input  logic            regWrite,
   input  logic [AW-1:0]   writeReg,
   input  logic [XLEN-1:0] writeData,
   input  logic            reserve,
   input  logic [AW-1:0]   reserveReg,
   input  logic            flush
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            wr_ok;
   logic            rd1_zero;
   logic            rd2_zero;

   assign wr_ok    = regWrite && !(ZERO_REG && (writeReg == AW'(REG_ZERO)));
   assign rd1_zero = ZERO_REG && (readReg1 == AW'(REG_ZERO));
   assign rd2_zero = ZERO_REG && (readReg2 == AW'(REG_ZERO));

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) regs_d[writeReg] = writeData;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) regs_q <= '{default: '0};
      else      regs_q <= regs_d;
   end

   // Outputs are gated by reset so a bypassed write cannot leak while reset is held.
   always_comb begin
      readData1 = '0;
      readData2 = '0;
      if (rst) begin
         if (rd1_zero)                              readData1 = '0;
         else if (regWrite && (writeReg == readReg1)) readData1 = writeData;
         else                                       readData1 = regs_q[readReg1];

         if (rd2_zero)                              readData2 = '0;
         else if (regWrite && (writeReg == readReg2)) readData2 = writeData;
         else                                       readData2 = regs_q[readReg2];
      end
   end

   reg_scoreboard #(
      .AW       (AW),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst),
      .flush       (flush),
      .clr_en      (regWrite),
      .clr_addr    (writeReg),
      .set_en      (reserve),
      .set_addr    (reserveReg),
      .query1_addr (readReg1),
      .query2_addr (readReg2),
      .query1_busy (busy1),
      .query2_busy (busy2)
   );

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: bypass, x0, scoreboard, flush, async reset.
module tb_reg_file_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  readReg1, readReg2, writeReg, reserveReg;
   logic [31:0] readData1, readData2, writeData;
   logic        busy1, busy2, regWrite, reserve, flush;

   int tests;
   int fails;

   reg_file_sb #(
      .XLEN     (32),
      .AW       (5),
      .NREGS    (32),
      .ZERO_REG (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .readReg1   (readReg1),
      .readReg2   (readReg2),
      .readData1  (readData1),
      .readData2  (readData2),
      .busy1      (busy1),
      .busy2      (busy2),
      .regWrite   (regWrite),
      .writeReg   (writeReg),
      .writeData  (writeData),
      .reserve    (reserve),
      .reserveReg (reserveReg),
      .flush      (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regWrite   = 1'b0;
      writeReg   = '0;
      writeData  = '0;
      reserve    = 1'b0;
      reserveReg = '0;
      flush      = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      readReg1 = 5'd5;
      readReg2 = 5'd31;
      idle();
      #12;
      // Reset held, including a pending write that must not bypass through.
      regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hABCD_0123;
      #1;
      chk("rst_rd1",   readData1, 32'h0);
      chk("rst_rd2",   readData2, 32'h0);
      chk("rst_busy1", {31'b0, busy1}, 32'h0);
      chk("rst_busy2", {31'b0, busy2}, 32'h0);
      idle();
      #1 rst = 1'b1;
      step();
      chk("post_rst_rd1", readData1, 32'h0);
      chk("post_rst_rd2", readData2, 32'h0);
      chk("post_rst_b2",  {31'b0, busy2}, 32'h0);

      // Write x7 with same-cycle bypass, then read back from storage.
      regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hDEAD_BEEF;
      readReg1 = 5'd7; readReg2 = 5'd5;
      #1;
      chk("bypass_rd1", readData1, 32'hDEAD_BEEF);
      chk("bypass_rd2_other", readData2, 32'h0);
      step();
      idle();
      readReg2 = 5'd7;
      #1;
      chk("stored_rd1", readData1, 32'hDEAD_BEEF);
      chk("stored_rd2", readData2, 32'hDEAD_BEEF);

      // x0 ignores writes and reservations.
      regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234_5678;
      reserve = 1'b1; reserveReg = 5'd0;
      readReg1 = 5'd0; readReg2 = 5'd0;
      #1;
      chk("x0_rd1_same", readData1, 32'h0);
      chk("x0_b1_same",  {31'b0, busy1}, 32'h0);
      step();
      idle();
      #1;
      chk("x0_rd2_after", readData2, 32'h0);
      chk("x0_b2_after",  {31'b0, busy2}, 32'h0);

      // Scoreboard lifecycle on x3.
      reserve = 1'b1; reserveReg = 5'd3; readReg1 = 5'd3;
      #1;
      chk("res3_same_cycle", {31'b0, busy1}, 32'h0);
      step();
      idle();
      #1;
      chk("res3_busy", {31'b0, busy1}, 32'h1);
      step();
      chk("res3_hold", {31'b0, busy1}, 32'h1);
      regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h55;
      #1;
      chk("wb3_busy_rel", {31'b0, busy1}, 32'h0);
      chk("wb3_bypass",   readData1, 32'h55);
      step();
      idle();
      #1;
      chk("wb3_busy_after", {31'b0, busy1}, 32'h0);
      chk("wb3_stored",     readData1, 32'h55);

      // Reserve and writeback on x9 in the same cycle: reserve wins, data stored.
      regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
      reserve = 1'b1; reserveReg = 5'd9;
      step();
      idle();
      readReg2 = 5'd9;
      #1;
      chk("x9_busy_kept", {31'b0, busy2}, 32'h1);
      chk("x9_stored",    readData2, 32'h99);
      regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h111;
      #1;
      chk("x9_clear_bypass", {31'b0, busy2}, 32'h0);
      chk("x9_data_bypass",  readData2, 32'h111);
      step();
      idle();
      #1;
      chk("x9_busy_cleared", {31'b0, busy2}, 32'h0);
      chk("x9_new_data",     readData2, 32'h111);

      // Flush overrides a concurrent reserve.
      reserve = 1'b1; reserveReg = 5'd1; step();
      reserveReg = 5'd2; step();
      reserveReg = 5'd4; step();
      reserveReg = 5'd1; // re-reserving a busy register is legal
      readReg1 = 5'd1; readReg2 = 5'd4;
      #1;
      chk("pre_flush_b1", {31'b0, busy1}, 32'h1);
      chk("pre_flush_b2", {31'b0, busy2}, 32'h1);
      flush = 1'b1; reserveReg = 5'd6;
      step();
      idle();
      #1;
      chk("flush_x1", {31'b0, busy1}, 32'h0);
      chk("flush_x4", {31'b0, busy2}, 32'h0);
      readReg1 = 5'd2; readReg2 = 5'd6;
      #1;
      chk("flush_x2", {31'b0, busy1}, 32'h0);
      chk("flush_x6", {31'b0, busy2}, 32'h0);

      // Asynchronous reset between edges.
      reserve = 1'b1; reserveReg = 5'd10;
      step();
      idle();
      readReg1 = 5'd10; readReg2 = 5'd7;
      #1;
      chk("pre_arst_b1",  {31'b0, busy1}, 32'h1);
      chk("pre_arst_rd2", readData2, 32'hDEAD_BEEF);
      #1 rst = 1'b0;
      #1;
      chk("arst_b1",  {31'b0, busy1}, 32'h0);
      chk("arst_rd2", readData2, 32'h0);
      readReg1 = 5'd3;
      #1;
      chk("arst_rd1_x3", readData1, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("after_arst_x7", readData2, 32'h0);
      chk("after_arst_x3", readData1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_reg_file_sb
